register_file: RTL and testbench

Parametrised multi-entry successor to the single `register` block. It provides DEPTH words of WIDTH bits with one write port and two registered read ports, write-first bypass, and a sequenced bulk-clear engine. It is the SUBNEG datapath's operand/scratch storage: the control unit reads A and B operands and writes the subtraction result back through it.

---
 rtl/register_file.sv | 133 +++++++++++++
 tb/tb_register_file.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Multi-entry register file: one write port, two registered read ports with
// write-first bypass, and a sequenced bulk-clear engine that walks every entry.
module register_file #(
    parameter int                 WIDTH       = 8,
    parameter int                 DEPTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    localparam int                AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Single effective write per cycle: either the external port or the clear engine.
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_data = wdata;
        case (state_q)
            IDLE: begin
                wr_en = we && ({1'b0, waddr} < DEPTH_W);
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = RESET_VALUE;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-first read: a write landing on the same edge wins over stored content.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (wr_en && (wr_addr == addr)) begin
            val = wr_data;
        end else if ({1'b0, addr} < DEPTH_W) begin
            val = mem_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        rdata_a_d = read_port(raddr_a);
        rdata_b_d = read_port(raddr_b);
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign mem_d[gi] = (wr_en && (wr_addr == AW'(gi))) ? wr_data : mem_q[gi];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    mem_q[gi] <= RESET_VALUE;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_a_q <= RESET_VALUE;
            rdata_b_q <= RESET_VALUE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign busy     = busy_q;
    assign clr_done = done_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: DEPTH=8 and DEPTH=6 instances share stimulus and are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_register_file;

    localparam int NDUT = 2;
    localparam int DEP [NDUT] = '{8, 6};

    logic       clk;
    logic       reset;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic       clr_req;

    logic [7:0] rda [NDUT];
    logic [7:0] rdb [NDUT];
    logic       bsy [NDUT];
    logic       dne [NDUT];

    int checks   = 0;
    int failures = 0;

    register_file #(.WIDTH(8), .DEPTH(8), .RESET_VALUE(8'h00)) u_dut8 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[0]), .rdata_b(rdb[0]),
        .clr_req(clr_req), .busy(bsy[0]), .clr_done(dne[0])
    );

    register_file #(.WIDTH(8), .DEPTH(6), .RESET_VALUE(8'h00)) u_dut6 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[1]), .rdata_b(rdb[1]),
        .clr_req(clr_req), .busy(bsy[1]), .clr_done(dne[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain arrays; clear progress is an integer position (-1 = idle).
    int  m_mem  [NDUT][8];
    int  m_ra   [NDUT];
    int  m_rb   [NDUT];
    int  m_busy [NDUT];
    int  m_done [NDUT];
    int  m_pos  [NDUT];
    bit  m_valid = 1'b0;

    function automatic int model_read(int d, int addr, int wen, int wa, int wd);
        if (wen != 0 && wa == addr) return wd;
        if (addr < DEP[d]) return m_mem[d][addr];
        return 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (!reset) begin
                    for (int k = 0; k < 8; k++) m_mem[d][k] = 0;
                    m_ra[d] = 0; m_rb[d] = 0; m_busy[d] = 0; m_done[d] = 0; m_pos[d] = -1;
                end else begin
                    int wen, wa, wd;
                    wen = 0; wa = 0; wd = 0;
                    if (m_pos[d] < 0) begin
                        if (we && int'(waddr) < DEP[d]) begin
                            wen = 1; wa = int'(waddr); wd = int'(wdata);
                        end
                    end else begin
                        wen = 1; wa = m_pos[d]; wd = 0;
                    end
                    m_ra[d] = model_read(d, int'(raddr_a), wen, wa, wd);
                    m_rb[d] = model_read(d, int'(raddr_b), wen, wa, wd);
                    m_done[d] = 0;
                    if (m_pos[d] < 0) begin
                        if (clr_req) begin
                            m_pos[d] = 0; m_busy[d] = 1;
                        end
                    end else if (m_pos[d] == DEP[d] - 1) begin
                        m_pos[d] = -1; m_busy[d] = 0; m_done[d] = 1;
                    end else begin
                        m_pos[d] = m_pos[d] + 1;
                    end
                    if (wen != 0) m_mem[d][wa] = wd;
                end
            end
            if (!reset) m_valid = 1'b1;
            @(negedge clk);
            if (m_valid) begin
                for (int d = 0; d < NDUT; d++) begin
                    checks++;
                    if (int'(rda[d]) != m_ra[d] || int'(rdb[d]) != m_rb[d] ||
                        int'(bsy[d]) != m_busy[d] || int'(dne[d]) != m_done[d]) begin
                        failures++;
                        $display("FAIL model_cmp dut%0d t=%0t got a=%02h b=%02h busy=%0d done=%0d exp a=%02h b=%02h busy=%0d done=%0d",
                                 d, $time, rda[d], rdb[d], bsy[d], dne[d],
                                 m_ra[d], m_rb[d], m_busy[d], m_done[d]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic wr(input int a, input int v);
        we = 1'b1; waddr = 3'(a); wdata = 8'(v);
        step();
        we = 1'b0;
    endtask

    task automatic rd(input int a, input int b);
        raddr_a = 3'(a); raddr_b = 3'(b);
        step();
    endtask

    int busy_cyc [NDUT];
    int done_cnt [NDUT];

    initial begin
        reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
        step();
        reset = 1'b1;
        chk("reset_rdata_a", int'(rda[0]), 0);
        chk("reset_busy", int'(bsy[0]), 0);
        chk("reset_done", int'(dne[0]), 0);

        // Preload 0x11..0x88 then reset
        for (int i = 0; i < 8; i++) wr(i, (i + 1) * 8'h11);
        rd(7, 0);
        chk("preload_e7", int'(rda[0]), 8'h88);
        chk("preload_e0", int'(rdb[0]), 8'h11);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("reset2_rdata_b", int'(rdb[0]), 0);
        chk("reset2_busy", int'(bsy[0]), 0);
        for (int i = 0; i < 8; i++) begin
            rd(i, 7 - i);
            chk($sformatf("reset2_entry%0d", i), int'(rda[0]), 0);
        end

        // Write then read
        wr(3, 8'hAA);
        wr(5, 8'h55);
        rd(3, 5);
        chk("rw_a3", int'(rda[0]), 8'hAA);
        chk("rw_b5", int'(rdb[0]), 8'h55);
        step();
        chk("rw_hold_a3", int'(rda[0]), 8'hAA);
        chk("rw_hold_b5", int'(rdb[0]), 8'h55);

        // Write-first bypass on both ports
        wr(2, 8'h12);
        raddr_a = 3'd2; raddr_b = 3'd2;
        wr(2, 8'h34);
        chk("bypass_a", int'(rda[0]), 8'h34);
        chk("bypass_b", int'(rdb[0]), 8'h34);

        // Bulk clear with a dropped write mid-clear
        for (int i = 0; i < 8; i++) wr(i, 8'hFF);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int d = 0; d < NDUT; d++) begin busy_cyc[d] = 0; done_cnt[d] = 0; end
        for (int c = 0; c < 12; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (bsy[d]) busy_cyc[d]++;
                if (dne[d]) done_cnt[d]++;
            end
            we = (c == 3); waddr = 3'd1; wdata = 8'h77;
            step();
        end
        we = 1'b0;
        chk("clear_busy_cycles_d8", busy_cyc[0], 8);
        chk("clear_done_pulses_d8", done_cnt[0], 1);
        chk("clear_busy_cycles_d6", busy_cyc[1], 6);
        chk("clear_done_pulses_d6", done_cnt[1], 1);
        for (int i = 0; i < 8; i++) begin
            rd(i, 1);
            chk($sformatf("clear_entry%0d", i), int'(rda[0]), 0);
        end
        chk("clear_dropped_write", int'(rdb[0]), 0);

        // Reset in the middle of a clear
        wr(6, 8'h5A);
        wr(7, 8'h5B);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midclr_busy", int'(bsy[0]), 0);
        chk("midclr_done", int'(dne[0]), 0);
        done_cnt[0] = 0;
        for (int i = 0; i < 8; i++) begin
            rd(i, i);
            if (dne[0]) done_cnt[0]++;
            chk($sformatf("midclr_entry%0d", i), int'(rda[0]), 0);
        end
        chk("midclr_no_done", done_cnt[0], 0);
        wr(7, 8'h9C);
        rd(7, 7);
        chk("midclr_wr7", int'(rda[0]), 8'h9C);

        // Out-of-range on the DEPTH=6 instance
        for (int i = 0; i < 6; i++) wr(i, 8'hA0 + i);
        wr(6, 8'hEE);
        for (int i = 0; i < 6; i++) begin
            rd(i, 6);
            chk($sformatf("oor_d6_entry%0d", i), int'(rda[1]), 8'hA0 + i);
        end
        chk("oor_d6_read6", int'(rdb[1]), 0);
        rd(7, 6);
        chk("oor_d6_read7", int'(rda[1]), 0);
        chk("oor_d8_entry6", int'(rdb[0]), 8'hEE);

        // Back-to-back clears with clr_req held high
        clr_req = 1'b1;
        repeat (20) step();
        clr_req = 1'b0;
        repeat (10) step();

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(0, 299) != 0);
            clr_req = ($urandom_range(0, 39) == 0);
            we      = $urandom_range(0, 1) == 1;
            waddr   = 3'($urandom_range(0, 7));
            wdata   = 8'($urandom_range(0, 255));
            raddr_a = 3'($urandom_range(0, 7));
            raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            step();
        end
        reset = 1'b1; clr_req = 1'b0; we = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
